// File: rtl/seq_mul_pkg.sv
// Shared definitions for the iterative shift-add multiplier: FSM state
// encoding, iteration-counter sizing and the parameter legality check.

`ifndef SEQ_MUL_PKG_SV
`define SEQ_MUL_PKG_SV

// Elaboration-time guard on the multiplier geometry; expands inside a module body.
`define SEQ_MUL_CHECK_PARAMS(W, B) \
    if ((W) < 4 || (W) > 64 || (B) < 1 || ((W) % (B)) != 0) begin : g_param_check \
        $error("seq_mul: WIDTH must be 4..64 and divisible by BITS_PER_CYCLE"); \
    end

package seq_mul_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // Width of a counter that runs 0..n-1; never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

`endif

// File: rtl/seq_mul_pp.sv
// Partial-product step: adds mcand * mplier_slice to the upper accumulator
// half. The sum is one slice wider than the operands so it never overflows.

module seq_mul_pp
    import seq_mul_pkg::*;
#(
    parameter int WIDTH          = 16,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic [WIDTH-1:0]                acc_hi,
    input  logic [WIDTH-1:0]                mcand,
    input  logic [BITS_PER_CYCLE-1:0]       mplier_slice,
    output logic [WIDTH+BITS_PER_CYCLE-1:0] sum
);

    localparam int SW = WIDTH + BITS_PER_CYCLE;

    // Shift-and-add over the retired multiplier bits of this iteration.
    always_comb begin
        sum = SW'(acc_hi);
        for (int i = 0; i < BITS_PER_CYCLE; i++) begin
            if (mplier_slice[i]) begin
                sum = sum + (SW'(mcand) << i);
            end
        end
    end

endmodule

// File: rtl/seq_mul.sv
// Iterative shift-add multiplier with valid/ready handshakes. Operands are
// reduced to magnitudes on entry and the sign is restored in a single FIX
// cycle, so signed and unsigned transactions share one datapath.

module seq_mul
    import seq_mul_pkg::*;
#(
    parameter int WIDTH          = 16,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 in_signed,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   product,
    output logic                 busy
);

    `SEQ_MUL_CHECK_PARAMS(WIDTH, BITS_PER_CYCLE)

    localparam int N     = WIDTH / BITS_PER_CYCLE;
    localparam int CNT_W = cnt_width(N);
    localparam int PW    = 2 * WIDTH;

    state_t                           state_q, state_d;
    logic [CNT_W-1:0]                 cnt_q, cnt_d;
    logic [WIDTH-1:0]                 a_mag_q, a_mag_d;
    logic [WIDTH-1:0]                 b_mag_q, b_mag_d;
    logic [PW-1:0]                    acc_q, acc_d;
    logic [PW-1:0]                    product_q, product_d;
    logic                             neg_q, neg_d;
    logic [WIDTH+BITS_PER_CYCLE-1:0]  pp_sum;
    logic [PW-1:0]                    acc_shift;

    seq_mul_pp #(
        .WIDTH          (WIDTH),
        .BITS_PER_CYCLE (BITS_PER_CYCLE)
    ) u_pp (
        .acc_hi       (acc_q[PW-1:WIDTH]),
        .mcand        (a_mag_q),
        .mplier_slice (b_mag_q[BITS_PER_CYCLE-1:0]),
        .sum          (pp_sum)
    );

    // New sum enters at the top while the accumulator slides right by one slice.
    if (BITS_PER_CYCLE == WIDTH) begin : g_shift_full
        assign acc_shift = pp_sum;
    end else begin : g_shift_part
        assign acc_shift = {pp_sum, acc_q[WIDTH-1:BITS_PER_CYCLE]};
    end

    // Next-state and datapath update; every state holds registers by default.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        a_mag_d   = a_mag_q;
        b_mag_d   = b_mag_q;
        acc_d     = acc_q;
        product_d = product_q;
        neg_d     = neg_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    a_mag_d = (in_signed && a[WIDTH-1]) ? -a : a;
                    b_mag_d = (in_signed && b[WIDTH-1]) ? -b : b;
                    neg_d   = in_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = ST_CALC;
                end
            end
            ST_CALC: begin
                acc_d   = acc_shift;
                b_mag_d = b_mag_q >> BITS_PER_CYCLE;
                if (cnt_q == CNT_W'(N - 1)) begin
                    cnt_d   = '0;
                    state_d = ST_FIX;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_FIX: begin
                product_d = neg_q ? -acc_q : acc_q;
                state_d   = ST_DONE;
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers; reset abandons any transaction in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            a_mag_q   <= '0;
            b_mag_q   <= '0;
            acc_q     <= '0;
            product_q <= '0;
            neg_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            a_mag_q   <= a_mag_d;
            b_mag_q   <= b_mag_d;
            acc_q     <= acc_d;
            product_q <= product_d;
            neg_q     <= neg_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign busy      = (state_q != ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign product   = product_q;

endmodule

// File: tb/tb_seq_mul.sv
// Bench for seq_mul: directed handshake/reset scenarios on a 16x16 radix-2
// instance, plus random operands on 8-bit/radix-16 and 32-bit/radix-4
// instances, all compared against an arithmetic reference product.

module tb_seq_mul;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    logic        in_valid, in_ready, in_signed, out_valid, out_ready, busy;
    logic [15:0] a, b;
    logic [31:0] product;

    logic        in_valid_8, in_ready_8, in_signed_8, out_valid_8, out_ready_8, busy_8;
    logic [7:0]  a_8, b_8;
    logic [15:0] product_8;

    logic        in_valid_32, in_ready_32, in_signed_32, out_valid_32, out_ready_32, busy_32;
    logic [31:0] a_32, b_32;
    logic [63:0] product_32;

    seq_mul #(.WIDTH(16), .BITS_PER_CYCLE(1)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_signed(in_signed), .a(a), .b(b), .out_valid(out_valid),
        .out_ready(out_ready), .product(product), .busy(busy)
    );

    seq_mul #(.WIDTH(8), .BITS_PER_CYCLE(4)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_8), .in_ready(in_ready_8),
        .in_signed(in_signed_8), .a(a_8), .b(b_8), .out_valid(out_valid_8),
        .out_ready(out_ready_8), .product(product_8), .busy(busy_8)
    );

    seq_mul #(.WIDTH(32), .BITS_PER_CYCLE(2)) dut32 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_32), .in_ready(in_ready_32),
        .in_signed(in_signed_32), .a(a_32), .b(b_32), .out_valid(out_valid_32),
        .out_ready(out_ready_32), .product(product_32), .busy(busy_32)
    );

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Exact product of w-bit operands, truncated to 2w bits.
    function automatic logic [127:0] ref_mul(input logic [63:0] x, input logic [63:0] y,
                                             input bit s, input int w);
        logic signed [63:0]  sx, sy;
        logic signed [127:0] px, py;
        logic [127:0]        p, mask;
        if (s) begin
            sx = $signed(x << (64 - w)) >>> (64 - w);
            sy = $signed(y << (64 - w)) >>> (64 - w);
            px = 128'(sx);
            py = 128'(sy);
            p  = px * py;
        end else begin
            p = {64'd0, x} * {64'd0, y};
        end
        mask = (128'd1 << (2 * w)) - 128'd1;
        return p & mask;
    endfunction

    // Operand mix biased toward corners: zero, all-ones, most-negative, one.
    function automatic logic [63:0] rnd_op(input int w);
        logic [63:0] mask;
        mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
        case ($urandom_range(0, 5))
            0: return 64'd0;
            1: return mask;
            2: return 64'd1 << (w - 1);
            3: return 64'd1;
            default: return {$urandom, $urandom} & mask;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic txn16(input logic [15:0] ta, input logic [15:0] tb, input bit ts);
        int lat;
        in_valid = 1'b1; a = ta; b = tb; in_signed = ts;
        tick();
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 100) begin
            tick();
            lat++;
        end
        check("lat16", lat, 17);
        check("prod16", product, ref_mul(64'(ta), 64'(tb), ts, 16));
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("drop16", out_valid, 1'b0);
    endtask

    task automatic txn8(input logic [7:0] ta, input logic [7:0] tb, input bit ts);
        int lat;
        in_valid_8 = 1'b1; a_8 = ta; b_8 = tb; in_signed_8 = ts;
        tick();
        in_valid_8 = 1'b0;
        lat = 0;
        while (!out_valid_8 && lat < 100) begin
            tick();
            lat++;
        end
        check("lat8", lat, 3);
        check("prod8", product_8, ref_mul(64'(ta), 64'(tb), ts, 8));
        out_ready_8 = 1'b1;
        tick();
        out_ready_8 = 1'b0;
    endtask

    task automatic txn32(input logic [31:0] ta, input logic [31:0] tb, input bit ts);
        int lat;
        in_valid_32 = 1'b1; a_32 = ta; b_32 = tb; in_signed_32 = ts;
        tick();
        in_valid_32 = 1'b0;
        lat = 0;
        while (!out_valid_32 && lat < 100) begin
            tick();
            lat++;
        end
        check("lat32", lat, 17);
        check("prod32", product_32, ref_mul(64'(ta), 64'(tb), ts, 32));
        out_ready_32 = 1'b1;
        tick();
        out_ready_32 = 1'b0;
    endtask

    initial begin
        logic [127:0] q[$];
        logic [127:0] exp_p;
        logic [63:0]  ra, rb;
        logic [15:0]  opa[6], opb[6];
        int           lat, results, last_t, idx, seen;
        bit           acc;

        rst_n = 1'b0;
        in_valid = 0; in_signed = 0; a = '0; b = '0; out_ready = 0;
        in_valid_8 = 0; in_signed_8 = 0; a_8 = '0; b_8 = '0; out_ready_8 = 0;
        in_valid_32 = 0; in_signed_32 = 0; a_32 = '0; b_32 = '0; out_ready_32 = 0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_product", product, 32'd0);
        rst_n = 1'b1;
        tick();

        // Unsigned and signed corner products
        txn16(16'hFFFF, 16'hFFFF, 1'b0);
        check("u_ffff_sq", product, 32'hFFFE0001);
        txn16(16'hFFFF, 16'hFFFF, 1'b1);
        check("s_m1_sq", product, 32'h00000001);
        txn16(16'h8000, 16'h0001, 1'b1);
        check("s_min_x1", product, 32'hFFFF8000);
        txn16(16'h8000, 16'h8000, 1'b1);
        check("s_min_sq", product, 32'h40000000);
        txn16(16'h0000, 16'h1234, 1'b0);

        // Backpressure: result held in DONE, in_valid pulses ignored
        in_valid = 1'b1; a = 16'h1234; b = 16'hA678; in_signed = 1'b1;
        exp_p = ref_mul(64'h1234, 64'hA678, 1'b1, 16);
        tick();
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 100) begin
            tick();
            lat++;
        end
        check("bp_lat", lat, 17);
        for (int i = 0; i < 10; i++) begin
            in_valid = (i % 2 == 0);
            a = 16'($urandom); b = 16'($urandom); in_signed = 1'($urandom);
            tick();
            check("bp_out_valid", out_valid, 1'b1);
            check("bp_product", product, exp_p);
            check("bp_in_ready", in_ready, 1'b0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("bp_drop", out_valid, 1'b0);
        check("bp_hold_product", product, exp_p);
        check("bp_idle", busy, 1'b0);

        // Asynchronous reset in the middle of CALC
        in_valid = 1'b1; a = 16'd7; b = 16'd9; in_signed = 1'b0;
        tick();
        in_valid = 1'b0;
        repeat (5) tick();
        rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", out_valid, 1'b0);
        check("mid_rst_product", product, 32'd0);
        check("mid_rst_in_ready", in_ready, 1'b1);
        check("mid_rst_busy", busy, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (out_valid) seen++;
        end
        check("mid_rst_no_pulse", seen, 0);
        txn16(16'd3, 16'd5, 1'b0);
        check("post_rst_3x5", product, 32'd15);

        // Back-to-back with in_valid held and out_ready held
        for (int i = 0; i < 6; i++) begin
            opa[i] = 16'($urandom);
            opb[i] = 16'($urandom);
        end
        idx = 0; results = 0; last_t = -1;
        a = opa[0]; b = opb[0]; in_signed = 1'b0;
        in_valid = 1'b1; out_ready = 1'b1;
        for (int cyc = 0; cyc < 200 && results < 5; cyc++) begin
            acc = in_ready;
            if (out_valid) begin
                if (q.size() > 0) check("b2b_prod", product, q.pop_front());
                else check("b2b_unexpected", out_valid, 1'b0);
                if (last_t >= 0) check("b2b_gap", cyc - last_t, 19);
                last_t = cyc;
                results++;
            end
            if (acc) q.push_back(ref_mul(64'(a), 64'(b), in_signed, 16));
            tick();
            if (acc) begin
                idx++;
                a = opa[idx % 6]; b = opb[idx % 6]; in_signed = idx[0];
            end
        end
        in_valid = 1'b0;
        check("b2b_count", results, 5);
        lat = 0;
        while (busy && lat < 40) begin
            tick();
            lat++;
        end
        check("b2b_drain", busy, 1'b0);
        out_ready = 1'b0;
        q.delete();

        // Random operand pairs on all three geometries
        repeat (150) begin
            ra = rnd_op(16); rb = rnd_op(16);
            txn16(ra[15:0], rb[15:0], 1'($urandom));
        end
        repeat (150) begin
            ra = rnd_op(8); rb = rnd_op(8);
            txn8(ra[7:0], rb[7:0], 1'($urandom));
        end
        repeat (150) begin
            ra = rnd_op(32); rb = rnd_op(32);
            txn32(ra[31:0], rb[31:0], 1'($urandom));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
